instr_queue: RTL

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue_pkg.sv | 15 +
 rtl/instr_queue.sv | 137 +++++++++++++
 2 files changed

// File: rtl/instr_queue_pkg.sv
// Shared frontend definitions: instruction-queue depth and the per-entry payload
// that is carried from fetch to decode.
package instr_queue_pkg;

    localparam int unsigned IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:2] instr;
        logic [31:0] pc;
        logic        pre_direction;
        logic [31:0] pre_pc;
        logic        is_compressed;
    } iq_entry_t;

endpackage : instr_queue_pkg

// File: rtl/instr_queue.sv
// Dual-issue fetch-to-decode instruction queue: circular buffer, two pushes and
// two pops per cycle, flush on redirect.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,

    input  logic                       valid_if_1,
    input  logic                       valid_if_2,
    input  logic [31:2]                instr_if_1,
    input  logic [31:2]                instr_if_2,
    input  logic [31:0]                pc_if_1,
    input  logic [31:0]                pc_if_2,
    input  logic                       pre_direction_if_1,
    input  logic                       pre_direction_if_2,
    input  logic [31:0]                pre_pc_if_1,
    input  logic [31:0]                pre_pc_if_2,
    input  logic                       instr_is_compressif_1,
    input  logic                       instr_is_compressif_2,
    output logic                       ready_if,

    input  logic                       de_ready,
    output logic                       valid_de_1,
    output logic                       valid_de_2,
    output logic [31:2]                instr_de_1,
    output logic [31:2]                instr_de_2,
    output logic [31:0]                pc_de_1,
    output logic [31:0]                pc_de_2,
    output logic                       pre_direction_de_1,
    output logic                       pre_direction_de_2,
    output logic [31:0]                pre_pc_de_1,
    output logic [31:0]                pre_pc_de_2,
    output logic                       instr_is_compressde_1,
    output logic                       instr_is_compressde_2,

    output logic [$clog2(DEPTH):0]     iq_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    iq_entry_t mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [1:0]       push_cnt;
    logic [1:0]       pop_cnt;
    logic             wr_en_1;
    logic             wr_en_2;

    iq_entry_t        wr_entry_1;
    iq_entry_t        wr_entry_2;
    iq_entry_t        rd_entry_1;
    iq_entry_t        rd_entry_2;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Acceptance looks only at registered occupancy, so fetch never depends on decode's ready.
    assign ready_if = (count_q <= CNT_W'(DEPTH - 2));

    assign push_cnt = ready_if ? {valid_if_1 & valid_if_2, valid_if_1 & ~valid_if_2} : 2'd0;
    assign pop_cnt  = !de_ready        ? 2'd0 :
                      (count_q >= 2)   ? 2'd2 : count_q[1:0];

    assign wr_en_1 = !reset && !flush && (push_cnt != 2'd0);
    assign wr_en_2 = !reset && !flush && (push_cnt == 2'd2);

    assign wr_entry_1 = '{instr: instr_if_1, pc: pc_if_1, pre_direction: pre_direction_if_1,
                          pre_pc: pre_pc_if_1, is_compressed: instr_is_compressif_1};
    assign wr_entry_2 = '{instr: instr_if_2, pc: pc_if_2, pre_direction: pre_direction_if_2,
                          pre_pc: pre_pc_if_2, is_compressed: instr_is_compressif_2};

    // NOTE: next-state logic uses blocking assignments with defaults first, so no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_cnt);
            tail_d  = tail_q + PTR_W'(push_cnt);
            count_d = count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy gating hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en_1) mem[tail_q]  <= wr_entry_1;
        if (wr_en_2) mem[tail_p1] <= wr_entry_2;
    end

    assign valid_de_1 = (count_q >= CNT_W'(1));
    assign valid_de_2 = (count_q >= CNT_W'(2));

    assign rd_entry_1 = valid_de_1 ? mem[head_q]  : '0;
    assign rd_entry_2 = valid_de_2 ? mem[head_p1] : '0;

    assign instr_de_1            = rd_entry_1.instr;
    assign pc_de_1               = rd_entry_1.pc;
    assign pre_direction_de_1    = rd_entry_1.pre_direction;
    assign pre_pc_de_1           = rd_entry_1.pre_pc;
    assign instr_is_compressde_1 = rd_entry_1.is_compressed;

    assign instr_de_2            = rd_entry_2.instr;
    assign pc_de_2               = rd_entry_2.pc;
    assign pre_direction_de_2    = rd_entry_2.pre_direction;
    assign pre_pc_de_2           = rd_entry_2.pre_pc;
    assign instr_is_compressde_2 = rd_entry_2.is_compressed;

    assign iq_count = count_q;

endmodule : instr_queue
